// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply; divide is unchanged.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enabled,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            completed,
  output logic [XLEN-1:0] rd
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [XLEN-1:0]   ZERO_X  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES_X  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   MIN_X   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ZERO_2X = {(2*XLEN){1'b0}};
  localparam logic [2*XLEN-1:0] ONE_2X  = {{(2*XLEN-1){1'b0}}, 1'b1};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_r;
  logic [2:0]        op_r;
  logic              neg_quo_r, neg_rem_r, busy_r, completed_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2*XLEN-1:0] acc_r, mcand_r, acc_nx_s;
  logic [XLEN-1:0]   mplier_r, rem_r, quo_r, dvsr_r, rd_r;
  logic [XLEN-1:0]   rem_nx_s, quo_nx_s, mag1_s, mag2_s, special_res_s;
  logic [XLEN:0]     rem_sh_s, diff_s;
  logic              sign1_s, sign2_s, neg1_s, neg2_s, div_zero_s, div_ovf_s;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_s;
`endif

  // Sign magnitude post-processing: the core works on magnitudes, signs are restored here.
  function automatic logic [XLEN-1:0] pick_result(
    input logic [2:0]        op,
    input logic [2*XLEN-1:0] prod_mag,
    input logic [XLEN-1:0]   quo_mag,
    input logic [XLEN-1:0]   rem_mag,
    input logic              neg_quo,
    input logic              neg_rem
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res;
    prod = neg_quo ? (~prod_mag + ONE_2X) : prod_mag;
    quo  = neg_quo ? (~quo_mag + ONE_X) : quo_mag;
    rem  = neg_rem ? (~rem_mag + ONE_X) : rem_mag;
    case (op)
      3'd0:             res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       res = quo;
      3'd6, 3'd7:       res = rem;
      default:          res = ZERO_X;
    endcase
    return res;
  endfunction

  // Decode operand signs, magnitudes and divide special cases at acceptance.
  always_comb begin
    sign1_s = 1'b0;
    sign2_s = 1'b0;
    case (funct3)
      3'd1, 3'd4, 3'd6: begin
        sign1_s = 1'b1;
        sign2_s = 1'b1;
      end
      3'd2:    sign1_s = 1'b1;
      default: begin
        sign1_s = 1'b0;
        sign2_s = 1'b0;
      end
    endcase
    neg1_s     = sign1_s & rs1[XLEN-1];
    neg2_s     = sign2_s & rs2[XLEN-1];
    mag1_s     = neg1_s ? (~rs1 + ONE_X) : rs1;
    mag2_s     = neg2_s ? (~rs2 + ONE_X) : rs2;
    div_zero_s = funct3[2] & (rs2 == ZERO_X);
    div_ovf_s  = funct3[2] & ~funct3[0] & (rs1 == MIN_X) & (rs2 == ONES_X);
    if (div_zero_s) begin
      special_res_s = funct3[1] ? rs1 : ONES_X;
    end else if (div_ovf_s) begin
      special_res_s = funct3[1] ? ZERO_X : rs1;
    end else begin
      special_res_s = ZERO_X;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod_s = {ZERO_X, mag1_s} * {ZERO_X, mag2_s};
`endif

  // One shift-add multiply step and one restoring divide step per cycle.
  always_comb begin
    acc_nx_s = acc_r + (mplier_r[0] ? mcand_r : ZERO_2X);
    rem_sh_s = {rem_r, quo_r[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, dvsr_r};
    if (diff_s[XLEN]) begin
      rem_nx_s = rem_sh_s[XLEN-1:0];
      quo_nx_s = {quo_r[XLEN-2:0], 1'b0};
    end else begin
      rem_nx_s = diff_s[XLEN-1:0];
      quo_nx_s = {quo_r[XLEN-2:0], 1'b1};
    end
  end

  // Control FSM plus datapath registers; rd is only written on the edge entering DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      op_r        <= 3'd0;
      neg_quo_r   <= 1'b0;
      neg_rem_r   <= 1'b0;
      busy_r      <= 1'b0;
      completed_r <= 1'b0;
      cnt_r       <= CNT_ZERO;
      acc_r       <= ZERO_2X;
      mcand_r     <= ZERO_2X;
      mplier_r    <= ZERO_X;
      rem_r       <= ZERO_X;
      quo_r       <= ZERO_X;
      dvsr_r      <= ZERO_X;
      rd_r        <= ZERO_X;
    end else begin
      case (state_r)
        IDLE: begin
          completed_r <= 1'b0;
          if (enabled) begin
            op_r      <= funct3;
            neg_quo_r <= neg1_s ^ neg2_s;
            neg_rem_r <= neg1_s;
            cnt_r     <= CNT_ZERO;
            acc_r     <= ZERO_2X;
            mcand_r   <= {ZERO_X, mag1_s};
            mplier_r  <= mag2_s;
            rem_r     <= ZERO_X;
            quo_r     <= mag1_s;
            dvsr_r    <= mag2_s;
            busy_r    <= 1'b1;
            if (div_zero_s || div_ovf_s) begin
              rd_r        <= special_res_s;
              completed_r <= 1'b1;
              state_r     <= DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!funct3[2]) begin
              rd_r        <= pick_result(funct3, fast_prod_s, ZERO_X, ZERO_X, neg1_s ^ neg2_s, neg1_s);
              completed_r <= 1'b1;
              state_r     <= DONE;
`endif
            end else begin
              state_r <= CALC;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        CALC: begin
          acc_r    <= acc_nx_s;
          mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
          rem_r    <= rem_nx_s;
          quo_r    <= quo_nx_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            rd_r        <= pick_result(op_r, acc_nx_s, quo_nx_s, rem_nx_s, neg_quo_r, neg_rem_r);
            completed_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          completed_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          completed_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign completed = completed_r;
  assign rd        = rd_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32 plus a reference-model sweep at XLEN=16.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enabled;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, rd;
  logic        busy, completed;

  logic        en16;
  logic [2:0]  f16;
  logic [15:0] a16, b16, rd16;
  logic        busy16, comp16;

  int checks = 0;
  int failures = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT32 = 1;
  localparam int MUL_LAT16 = 1;
`else
  localparam int MUL_LAT32 = 33;
  localparam int MUL_LAT16 = 17;
`endif

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) u_dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .busy(busy), .completed(completed), .rd(rd)
  );

  muldiv_unit #(.XLEN(16)) u_dut16 (
    .clk(clk), .rstn(rstn), .enabled(en16), .funct3(f16),
    .rs1(a16), .rs2(b16), .busy(busy16), .completed(comp16), .rd(rd16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic op32(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; enabled = 1'b1;
    @(negedge clk);
    enabled = 1'b0;
    lat = 1;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (!completed && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done"}, {31'd0, completed}, 32'd1);
    check(tag, rd, exp_res);
    check({tag, "_lat"}, lat, exp_lat);
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, completed, busy}, 32'd0);
  endtask

  function automatic logic [15:0] ref16(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, ua, ub, p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({48'd0, a});
    ub  = longint'({48'd0, b});
    ovf = (a == 16'h8000) && (b == 16'hFFFF);
    p   = 64'sd0;
    case (f)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; p = p >>> 16; end
      3'd2: begin p = sa * ub; p = p >>> 16; end
      3'd3: begin p = ua * ub; p = p >>> 16; end
      3'd4: p = (b == 16'd0) ? 64'sd65535 : (ovf ? 64'sd32768 : sa / sb);
      3'd5: p = (b == 16'd0) ? 64'sd65535 : ua / ub;
      3'd6: p = (b == 16'd0) ? ua : (ovf ? 64'sd0 : sa % sb);
      3'd7: p = (b == 16'd0) ? ua : ua % ub;
      default: p = 64'sd0;
    endcase
    return p[15:0];
  endfunction

  initial begin
    int lat, npulse;
    logic [31:0] first_rd;
    logic [15:0] a, b;
    logic [2:0]  fv;
    int exp_lat;

    rstn = 1'b0; enabled = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    en16 = 1'b0; f16 = 3'd0; a16 = 16'd0; b16 = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_state", {rd[29:0], busy, completed}, 32'd0);
    rstn = 1'b1;

    // Directed vectors.
    op32("mul_7_m3",   3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT32);
    op32("mulh",       3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, MUL_LAT32);
    op32("mulhsu",     3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, MUL_LAT32);
    op32("mulhu",      3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, MUL_LAT32);
    op32("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    op32("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    op32("divu_100_7", 3'd5, 32'd100,      32'd7,        32'd14,       33);
    op32("divu_by0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    op32("remu_by0",   3'd7, 32'd5,        32'd0,        32'd5,        1);
    op32("div_by0",    3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1);
    op32("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    op32("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // A second enabled pulse while busy must be dropped.
    @(negedge clk);
    funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; enabled = 1'b1;
    @(negedge clk);
    enabled = 1'b0;
    npulse = 0; lat = 0; first_rd = 32'd0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) begin
        funct3 = 3'd5; rs1 = 32'd50; rs2 = 32'd5; enabled = 1'b1;
      end else if (c == 11) begin
        enabled = 1'b0;
      end
      if (completed) begin
        npulse++;
        lat = c;
        first_rd = rd;
      end
      @(negedge clk);
    end
    check("busy_ignore_pulses", npulse, 32'd1);
    check("busy_ignore_rd", first_rd, 32'd142);
    check("busy_ignore_lat", lat, 32'd33);
    check("busy_ignore_rd_held", rd, 32'd142);

    // Reset in the middle of a multiply.
    funct3 = 3'd0; rs1 = 32'h1234; rs2 = 32'h5678; enabled = 1'b1;
    @(negedge clk);
    enabled = 1'b0;
    repeat (19) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midop_reset_busy", {31'd0, busy}, 32'd0);
    check("midop_reset_rd", rd, 32'd0);
    check("midop_reset_completed", {31'd0, completed}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    npulse = 0;
    repeat (40) begin
      @(negedge clk);
      if (completed) npulse++;
    end
    check("midop_reset_no_pulse", npulse, 32'd0);
    op32("mul_after_reset", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT32);

    // XLEN=16 sweep against a reference model.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 3; k++) begin
        fv = f[2:0];
        a  = $urandom_range(0, 65535);
        b  = $urandom_range(0, 65535);
        if (k == 2) begin
          a = 16'h8000;
          b = 16'hFFFF;
        end
        if (!fv[2]) exp_lat = MUL_LAT16;
        else if (b == 16'd0 || (!fv[0] && a == 16'h8000 && b == 16'hFFFF)) exp_lat = 1;
        else exp_lat = 17;
        @(negedge clk);
        f16 = fv; a16 = a; b16 = b; en16 = 1'b1;
        @(negedge clk);
        en16 = 1'b0;
        lat = 1;
        while (!comp16 && lat < 60) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("x16_f%0d_%h_%h", f, a, b), {16'd0, rd16}, {16'd0, ref16(fv, a, b)});
        check($sformatf("x16_f%0d_lat", f), lat, exp_lat);
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit, parametrised in operand width, that sits beside the single-cycle ALU in the execute stage. It accepts one M-extension operation per `enabled` pulse, computes it over multiple cycles with a shift-add multiplier or a restoring divider, and raises `completed` for one cycle when `rd` is valid. The execute stage stalls issue while `busy` is high.

## Interface
- `XLEN`, 32: operand and result width (even, ≥ 8).
- `clk`  in  1  clock; all state updates on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `enabled`  in  1  start request; sampled only in IDLE.
- `funct3`  in  3  M-extension op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1`  in  XLEN  first operand (multiplicand / dividend).
- `rs2`  in  XLEN  second operand (multiplier / divisor).
- `busy`  out  1  high from the cycle after acceptance until the cycle `completed` is asserted, inclusive.
- `completed`  out  1  single-cycle pulse; `rd` valid.
- `rd`  out  XLEN  result, held until the next accepted operation completes.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: if `enabled`=1, latch `funct3`, `rs1`, `rs2`; set operand signs per op (MULH: both signed; MULHSU: rs1 signed only; DIV/REM: both signed; others unsigned); store magnitudes; clear counter; go to CALC. Otherwise stay in IDLE.
- Division special cases are resolved at acceptance and go directly to DONE:
  - `rs2`=0: DIV/DIVU quotient = all ones; REM/REMU remainder = `rs1`.
  - DIV/REM signed overflow (`rs1`=1<<(XLEN-1), `rs2`=all ones): quotient = `rs1`; remainder = 0.
- CALC, multiply: one partial-product add per cycle into a 2·XLEN accumulator, multiplier shifted right by 1; XLEN iterations.
- CALC, divide: one restoring step per cycle (shift remainder left, trial subtract, set quotient bit); XLEN iterations.
- Counter width is clog2(XLEN)+1. The last CALC iteration is the one with counter = XLEN-1; the next state is DONE.
- Entering DONE: negate the product when operand signs differ; for a signed quotient, negate when the signs differ; for a signed remainder, negate when the dividend is negative. Select the low XLEN bits (MUL), the high XLEN bits (MULH*), the quotient, or the remainder. Register the result into `rd`.
- DONE: `completed`=1 for exactly one cycle; next state IDLE. `enabled` is ignored in DONE.
- `enabled` while `busy` is ignored; there is no queueing.

## Timing
- Reset: asynchronous. `rstn`=0 forces IDLE immediately and clears `busy`=0, `completed`=0, `rd`=0, the counter, and the accumulators. Reset mid-operation discards the operation; no `completed` pulse is produced.
- Accept at edge T (IDLE, `enabled`=1). For the normal path, CALC occupies cycles T+1..T+XLEN and DONE occupies T+XLEN+1. Latency is XLEN+1 cycles.
- Division special case: DONE at T+1, latency 1.
- Back-to-back: IDLE at T+XLEN+2 can accept again, giving a throughput of one operation per XLEN+2 cycles.
- `rd` changes only on the edge entering DONE.

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - Defined: multiply uses a single-cycle combinational 2·XLEN product; all multiply ops go IDLE→DONE with latency 1.
  - Undefined: iterative shift-add multiply with latency XLEN+1.
  - Divide behaviour is identical in both builds.

## Test plan
- MUL, `rs1`=7, `rs2`=-3 (0xFFFFFFFD) → `rd`=0xFFFFFFEB; `completed` 33 cycles after acceptance (1 cycle with `MULDIV_FAST_MUL_EN`).
- MULH / MULHSU / MULHU, `rs1`=0x80000000, `rs2`=0xFFFFFFFF → `rd`=0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV / REM, `rs1`=-7, `rs2`=2 → `rd`=0xFFFFFFFD (-3) / 0xFFFFFFFF (-1); DIVU, `rs1`=100, `rs2`=7 → `rd`=14.
- Divide by zero, DIVU `rs1`=5, `rs2`=0 → `rd`=0xFFFFFFFF one cycle after acceptance; REMU → `rd`=5. Overflow, DIV 0x80000000 / 0xFFFFFFFF → `rd`=0x80000000, latency 1.
- Pulse `enabled` at cycle 10 of a DIVU while busy → ignored, single `completed`, `rd` from the first op only; drop `rstn` at cycle 20 of a MUL → `busy`=0 and `rd`=0 immediately, no `completed`, and the next op is accepted normally.
- Parameter sweep with `XLEN`=16: random operands against a reference model, checking latency of 17 cycles and the result for all eight `funct3` values.
